// File: rtl/fork_join_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fork_join_ctrl_if
//  Description : Control/status bundle between a sequencing master and the
//                fork/join controller. The master drives the fork request and
//                worker completions; the controller returns fork/join status.
//  Revision    : 1.0  initial release
// ============================================================================
interface fork_join_ctrl_if #(
  parameter int N_CHAN = 4,
  parameter int TMO_W  = 8
);
  localparam int IDX_W = $clog2(N_CHAN);

  logic              start;
  logic [1:0]        mode;
  logic [N_CHAN-1:0] chan_mask;
  logic [TMO_W-1:0]  tmo_limit;
  logic [N_CHAN-1:0] done_i;
  logic [N_CHAN-1:0] fork_o;
  logic              join_o;
  logic [IDX_W-1:0]  winner_o;
  logic [N_CHAN-1:0] pending_o;
  logic              all_done_o;
  logic              timeout_o;
  logic              busy;

  modport master (
    output start, mode, chan_mask, tmo_limit, done_i,
    input  fork_o, join_o, winner_o, pending_o, all_done_o, timeout_o, busy
  );

  modport slave (
    input  start, mode, chan_mask, tmo_limit, done_i,
    output fork_o, join_o, winner_o, pending_o, all_done_o, timeout_o, busy
  );
endinterface
`default_nettype wire

// File: rtl/fork_join_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fork_join_ctrl
//  Description : Fork/join controller. One accepted start forks the masked
//                worker channels, tracks their completions and signals the
//                join in JOIN_ALL / JOIN_ANY / JOIN_NONE mode, with an
//                optional cycle timeout that aborts the transaction.
//                N_CHAN/TMO_W must match the connected interface instance.
//  Revision    : 1.0  initial release
// ============================================================================
module fork_join_ctrl #(
  parameter int N_CHAN = 4,
  parameter int TMO_W  = 8
) (
  input  wire             clk,
  input  wire             rst_n,
  fork_join_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(N_CHAN);

  localparam logic [1:0] c_MODE_ANY  = 2'b01;
  localparam logic [1:0] c_MODE_NONE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state,   w_state_nxt;
  logic [1:0]        r_mode,    w_mode_nxt;
  logic [TMO_W-1:0]  r_limit,   w_limit_nxt;
  logic [TMO_W-1:0]  r_cnt,     w_cnt_nxt;
  logic [N_CHAN-1:0] r_pending, w_pending_nxt;
  logic [N_CHAN-1:0] r_fork,    w_fork_nxt;
  logic              r_join,    w_join_nxt;
  logic              r_all,     w_all_nxt;
  logic              r_tmo,     w_tmo_nxt;
  logic [IDX_W-1:0]  r_winner,  w_winner_nxt;

  logic [N_CHAN-1:0] w_hit;
  logic [IDX_W-1:0]  w_win;
  logic              w_tmo_hit;

  // Completions that actually retire a pending channel this cycle.
  assign w_hit = bus.done_i & r_pending;

  // Abort when the counter reaches limit-1 with work still outstanding.
  assign w_tmo_hit = (r_limit != '0) && (r_cnt == r_limit - 1'b1) && (r_pending != '0);

  // Lowest set index of the retiring vector; scanning downward lets the lowest win ties.
  always_comb begin
    w_win = '0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (w_hit[i]) w_win = IDX_W'(i);
    end
  end

  // Next-state and next-output logic; all pulses default low every cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_limit_nxt   = r_limit;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_fork_nxt    = '0;
    w_join_nxt    = 1'b0;
    w_all_nxt     = 1'b0;
    w_tmo_nxt     = 1'b0;
    w_winner_nxt  = r_winner;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_mode_nxt    = bus.mode;
          w_limit_nxt   = bus.tmo_limit;
          w_cnt_nxt     = '0;
          w_pending_nxt = bus.chan_mask;
          w_fork_nxt    = bus.chan_mask;
          if (bus.chan_mask == '0) begin
            // Nothing to fork: join and finish immediately, stay idle.
            w_join_nxt   = 1'b1;
            w_all_nxt    = 1'b1;
            w_winner_nxt = '0;
          end else if (bus.mode == c_MODE_NONE) begin
            w_join_nxt   = 1'b1;
            w_winner_nxt = '0;
            w_state_nxt  = ST_DRAIN;
          end else begin
            w_state_nxt  = ST_WAIT;
          end
        end
      end

      ST_WAIT, ST_DRAIN: begin
        w_pending_nxt = r_pending & ~bus.done_i;
        w_cnt_nxt     = (r_cnt == {TMO_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
        if (w_pending_nxt == '0) begin
          // Final completion beats a coincident timeout.
          w_all_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
          if (r_state == ST_WAIT) begin
            w_join_nxt   = 1'b1;
            w_winner_nxt = (r_mode == c_MODE_ANY) ? w_win : '0;
          end
        end else if (w_tmo_hit) begin
          w_tmo_nxt     = 1'b1;
          w_pending_nxt = '0;
          w_state_nxt   = ST_IDLE;
        end else if ((r_state == ST_WAIT) && (r_mode == c_MODE_ANY) && (w_hit != '0)) begin
          w_join_nxt   = 1'b1;
          w_winner_nxt = w_win;
          w_state_nxt  = ST_DRAIN;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset silently drops any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mode    <= '0;
      r_limit   <= '0;
      r_cnt     <= '0;
      r_pending <= '0;
      r_fork    <= '0;
      r_join    <= 1'b0;
      r_all     <= 1'b0;
      r_tmo     <= 1'b0;
      r_winner  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_limit   <= w_limit_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
      r_fork    <= w_fork_nxt;
      r_join    <= w_join_nxt;
      r_all     <= w_all_nxt;
      r_tmo     <= w_tmo_nxt;
      r_winner  <= w_winner_nxt;
    end
  end

  assign bus.fork_o     = r_fork;
  assign bus.join_o     = r_join;
  assign bus.winner_o   = r_winner;
  assign bus.pending_o  = r_pending;
  assign bus.all_done_o = r_all;
  assign bus.timeout_o  = r_tmo;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fork_join_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fork_join_ctrl
//  Description : Directed self-checking bench for fork_join_ctrl. Expected
//                output pulses are queued with their cycle when stimulus is
//                driven and matched when the controller emits them; pending
//                and busy are checked directly after each step.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fork_join_ctrl;

  localparam int N  = 4;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  typedef struct {
    int         cyc;
    logic [8:0] outs;
  } ev_t;

  ev_t        sb[$];
  ev_t        m_ev;
  logic [8:0] m_obs;

  fork_join_ctrl_if #(.N_CHAN(N), .TMO_W(TW)) bus ();

  fork_join_ctrl #(.N_CHAN(N), .TMO_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [8:0] pk(input logic [3:0] f, input logic j, input logic [1:0] w,
                                    input logic a, input logic t);
    return {f, j, w, a, t};
  endfunction

  task automatic expect_ev(input int at, input logic [3:0] f, input logic j, input logic [1:0] w,
                           input logic a, input logic t);
    ev_t e;
    e.cyc  = at;
    e.outs = pk(f, j, w, a, t);
    sb.push_back(e);
  endtask

  // Match every output pulse against the oldest expected event.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.fork_o != '0 || bus.join_o || bus.all_done_o || bus.timeout_o)) begin
      m_obs = pk(bus.fork_o, bus.join_o, bus.join_o ? bus.winner_o : 2'b00,
                 bus.all_done_o, bus.timeout_o);
      if (sb.size() == 0) begin
        check("unexpected_event", {23'd0, m_obs}, 32'd0);
      end else begin
        m_ev = sb.pop_front();
        check("event_cycle", cyc, m_ev.cyc);
        check("event_outputs", {23'd0, m_obs}, {23'd0, m_ev.outs});
      end
    end
  end

  // Drive done_i for one cycle; returns at the next falling edge.
  task automatic step(input logic [3:0] d);
    bus.done_i = d;
    @(negedge clk);
    bus.done_i = '0;
  endtask

  // Issue a start; returns in cycle F. j/a give the expected join/all_done in F.
  task automatic start_txn(input logic [1:0] m, input logic [3:0] mask, input logic [7:0] lim,
                           input logic j, input logic a);
    bus.start     = 1'b1;
    bus.mode      = m;
    bus.chan_mask = mask;
    bus.tmo_limit = lim;
    expect_ev(cyc + 1, mask, j, 2'b00, a, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] p, input logic b);
    check({tag, "_pending"}, {28'd0, bus.pending_o}, {28'd0, p});
    check({tag, "_busy"}, {31'd0, bus.busy}, {31'd0, b});
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_fork"},    {28'd0, bus.fork_o},     32'd0);
    check({tag, "_join"},    {31'd0, bus.join_o},     32'd0);
    check({tag, "_winner"},  {30'd0, bus.winner_o},   32'd0);
    check({tag, "_alldone"}, {31'd0, bus.all_done_o}, 32'd0);
    check({tag, "_timeout"}, {31'd0, bus.timeout_o},  32'd0);
    chk_state(tag, 4'b0000, 1'b0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.mode      = 2'b00;
    bus.chan_mask = '0;
    bus.tmo_limit = '0;
    bus.done_i    = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // JOIN_ALL with staggered completions.
    start_txn(2'b00, 4'b1011, 8'd0, 1'b0, 1'b0);
    chk_state("all_F", 4'b1011, 1'b1);
    step(4'b0000);
    step(4'b0001);
    chk_state("all_ch0", 4'b1010, 1'b1);
    step(4'b0000);
    step(4'b0000);
    step(4'b1000);
    chk_state("all_ch3", 4'b0010, 1'b1);
    step(4'b0000);
    expect_ev(cyc + 1, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0);
    step(4'b0010);
    chk_state("all_end", 4'b0000, 1'b0);

    // JOIN_ANY, two simultaneous finishers: lowest index wins.
    start_txn(2'b01, 4'b1111, 8'd0, 1'b0, 1'b0);
    step(4'b0000);
    expect_ev(cyc + 1, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
    step(4'b0110);
    chk_state("any_drain", 4'b1001, 1'b1);
    step(4'b0001);
    chk_state("any_ch0", 4'b1000, 1'b1);
    expect_ev(cyc + 1, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
    step(4'b1000);
    chk_state("any_end", 4'b0000, 1'b0);
    check("any_winner_hold", {30'd0, bus.winner_o}, 32'd1);

    // JOIN_ANY where the first completion also retires the last channel, done in F.
    start_txn(2'b01, 4'b1100, 8'd0, 1'b0, 1'b0);
    expect_ev(cyc + 1, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0);
    step(4'b1100);
    chk_state("any_last", 4'b0000, 1'b0);

    // JOIN_NONE: join with fork; done during F honoured.
    start_txn(2'b10, 4'b0101, 8'd0, 1'b1, 1'b0);
    chk_state("none_F", 4'b0101, 1'b1);
    step(4'b0001);
    chk_state("none_ch0", 4'b0100, 1'b1);
    step(4'b0000);
    step(4'b0000);
    chk_state("none_wait", 4'b0100, 1'b1);
    expect_ev(cyc + 1, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
    step(4'b0100);
    chk_state("none_end", 4'b0000, 1'b0);

    // Timeout: limit 10, ch1 never finishes.
    start_txn(2'b00, 4'b0011, 8'd10, 1'b0, 1'b0);
    f = cyc;
    step(4'b0001);
    chk_state("tmo_ch0", 4'b0010, 1'b1);
    expect_ev(f + 10, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    repeat (9) step(4'b0000);
    chk_state("tmo_abort", 4'b0000, 1'b0);
    start_txn(2'b00, 4'b0001, 8'd0, 1'b0, 1'b0);
    expect_ev(cyc + 1, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0);
    step(4'b0001);
    chk_state("tmo_restart", 4'b0000, 1'b0);

    // Final done in the same cycle as the timeout: completion wins.
    start_txn(2'b00, 4'b0001, 8'd3, 1'b0, 1'b0);
    step(4'b0000);
    step(4'b0000);
    expect_ev(cyc + 1, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0);
    step(4'b0001);
    chk_state("tmo_race", 4'b0000, 1'b0);

    // Empty mask.
    start_txn(2'b00, 4'b0000, 8'd0, 1'b1, 1'b1);
    chk_state("empty_F", 4'b0000, 1'b0);

    // Start while busy is ignored; done on a non-forked channel is ignored.
    start_txn(2'b00, 4'b0011, 8'd0, 1'b0, 1'b0);
    bus.start     = 1'b1;
    bus.chan_mask = 4'b1100;
    step(4'b0000);
    step(4'b0000);
    bus.start = 1'b0;
    chk_state("busy_start", 4'b0011, 1'b1);
    step(4'b0100);
    chk_state("stray_done", 4'b0011, 1'b1);
    expect_ev(cyc + 1, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0);
    step(4'b0011);
    chk_state("busy_end", 4'b0000, 1'b0);

    // Asynchronous reset mid-WAIT.
    start_txn(2'b00, 4'b1011, 8'd0, 1'b0, 1'b0);
    step(4'b0001);
    chk_state("rst_pre", 4'b1010, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_txn(2'b00, 4'b1011, 8'd0, 1'b0, 1'b0);
    chk_state("post_rst_F", 4'b1011, 1'b1);
    expect_ev(cyc + 1, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0);
    step(4'b1011);
    chk_state("post_rst_end", 4'b0000, 1'b0);

    repeat (3) step(4'b0000);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fork_join_ctrl.md
Name: fork_join_ctrl

Overview:
Parametrised hardware fork/join controller. One `start` forks up to N_CHAN worker channels and collects their completion pulses. It signals the join according to a per-transaction mode: JOIN_ALL, JOIN_ANY or JOIN_NONE. It sits between a sequencing master and a bank of worker engines, and adds completion tracking and a cycle timeout.

Parameters:
N_CHAN, 4, number of worker channels (2..32)
TMO_W, 8, width of the timeout counter and of tmo_limit
IDX_W, $clog2(N_CHAN), width of winner_o (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new fork; accepted only when busy=0
mode  input  2  join mode sampled with start: 00 JOIN_ALL, 01 JOIN_ANY, 10 JOIN_NONE, 11 reserved (treated as JOIN_ALL)
chan_mask  input  N_CHAN  channels to fork, sampled with start
tmo_limit  input  TMO_W  timeout in cycles, sampled with start; 0 disables the timeout
done_i  input  N_CHAN  per-channel completion pulses
fork_o  output  N_CHAN  one-cycle fork pulse per selected channel
join_o  output  1  one-cycle pulse when the join condition is met
winner_o  output  IDX_W  index of the first finisher (valid with join_o in JOIN_ANY mode; otherwise 0)
pending_o  output  N_CHAN  forked channels not yet done
all_done_o  output  1  one-cycle pulse when every forked channel has finished
timeout_o  output  1  one-cycle pulse on timeout abort
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state returns to IDLE. All outputs are 0 and all internal registers are cleared. Reset mid-transaction drops it silently: no join_o, all_done_o or timeout_o pulse.
- States: IDLE, WAIT, DRAIN.
  - DRAIN means the join has already been issued and forked channels are still pending.
- Start acceptance:
  - In IDLE, start=1 is accepted at the clock edge.
  - start is ignored whenever busy=1.
  - At the accept edge: mode, tmo_limit and chan_mask are latched, pending_o is set to chan_mask, and the timeout counter is cleared.
  - In the following cycle (cycle F), fork_o equals chan_mask for exactly one cycle.
- Empty mask: if chan_mask=0 at accept, cycle F carries fork_o=0, join_o=1 and all_done_o=1, and the state returns to IDLE.
- Done handling:
  - done_i[k] clears pending_o[k] at the edge where it is sampled high, but only if pending_o[k]=1. done_i on a non-pending bit is ignored.
  - done_i is honoured during cycle F (zero-latency workers are supported).
- JOIN_NONE:
  - join_o pulses in cycle F together with fork_o; the state goes to DRAIN (or straight to IDLE if the mask is empty).
- JOIN_ANY:
  - At the first edge where (done_i & pending_o) is non-zero, join_o pulses the next cycle.
  - winner_o is registered as the lowest set index of that vector, so ties resolve to the lowest index.
  - The state goes to DRAIN. If that done cleared the last pending bit, all_done_o pulses in the same cycle as join_o and the state goes to IDLE.
- JOIN_ALL:
  - join_o and all_done_o pulse together, in the cycle after pending_o becomes 0.
- Return to IDLE:
  - The cycle carrying all_done_o is the first IDLE cycle, so busy=0 there and a start in that cycle is accepted.
  - In DRAIN, all_done_o pulses in the cycle after pending_o becomes 0.
- Timeout:
  - The counter increments in each WAIT or DRAIN cycle (TMO_W bits, saturating).
  - If tmo_limit≠0 and the counter equals tmo_limit-1 while pending_o≠0, the controller aborts. The next cycle has timeout_o=1, pending_o=0 and state IDLE.
  - No join_o (if not yet issued) and no all_done_o are produced by the abort.
  - If the final done and the timeout coincide in the same cycle, the done wins: normal completion, no timeout_o.
- Outputs fork_o, join_o, all_done_o and timeout_o are registered single-cycle pulses. winner_o holds its value until the next join_o.

Test Plan:
1. N_CHAN=4, JOIN_ALL, mask=4'b1011, done on ch0@+2, ch3@+5, ch1@+7 → fork_o=1011 in cycle F. join_o and all_done_o pulse together once, one cycle after the ch1 done. pending_o steps 1011→1010→0010→0000.
2. JOIN_ANY, mask=4'b1111, done_i=4'b0110 in one cycle, remaining channels later → join_o pulses with winner_o=1, state is DRAIN. all_done_o pulses after ch0 and ch3 finish; no second join_o.
3. JOIN_NONE, mask=4'b0101 → join_o and fork_o both high in cycle F. busy stays high until both channels are done, then all_done_o=1 and busy=0.
4. Timeout: JOIN_ALL, mask=4'b0011, tmo_limit=10, only ch0 done → timeout_o pulses 10 cycles after cycle F. pending_o=0, no join_o, and a new start is accepted immediately after.
5. Edge cases: mask=0 gives join_o=all_done_o=1 in cycle F. start while busy is ignored (fork_o not re-pulsed). A done_i on a non-forked channel leaves pending_o unchanged.
6. Reset: assert rst_n=0 asynchronously mid-WAIT → all outputs are 0 immediately with no clock edge needed. After release, the controller is idle and the next start behaves as in scenario 1.
